// File: rtl/pu_multiplexer_n.sv
// N-way select processing unit: collects up to 2**SEL_WIDTH argument words, then a
// selector word, and drives the chosen argument (with its attributes) onto the bus.
module pu_multiplexer_n #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ATTR_WIDTH  = 4,
  parameter int unsigned SEL_WIDTH   = 2,
  parameter int unsigned INVALID_BIT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signal_wr,
  input  logic                  signal_sel,
  input  logic                  signal_oe,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ATTR_WIDTH-1:0] attr_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ATTR_WIDTH-1:0] attr_out,
  output logic                  busy
);

  localparam int unsigned N  = 2**SEL_WIDTH;
  localparam int unsigned CW = SEL_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_ARMED,
    S_OUTPUT
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q [N];
  logic [DATA_WIDTH-1:0] data_d [N];
  logic [ATTR_WIDTH-1:0] attr_q [N];
  logic [ATTR_WIDTH-1:0] attr_d [N];
  logic [CW-1:0]         count_q, count_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic                  sel_oor_q, sel_oor_d;
  logic                  ovf_q, ovf_d;
  logic                  busy_q;

  logic                  sel_oor_in;
  logic                  not_full;
  logic                  valid;
  logic [SEL_WIDTH-1:0]  wr_idx;

  // Any bit above the selector field (sign included) puts the selector out of range.
  assign sel_oor_in = |data_in[DATA_WIDTH-1:SEL_WIDTH];
  assign not_full   = count_q < CW'(N);
  assign wr_idx     = count_q[SEL_WIDTH-1:0];

  // Job sequencing and argument/selector capture; sel beats wr, wr beats oe.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    attr_d    = attr_q;
    count_d   = count_q;
    sel_d     = sel_q;
    sel_oor_d = sel_oor_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (signal_sel) begin
          sel_d     = data_in[SEL_WIDTH-1:0];
          sel_oor_d = sel_oor_in;
          state_d   = S_ARMED;
        end else if (signal_wr) begin
          data_d[0] = data_in;
          attr_d[0] = attr_in;
          count_d   = CW'(1);
          state_d   = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (signal_sel) begin
          sel_d     = data_in[SEL_WIDTH-1:0];
          sel_oor_d = sel_oor_in;
          state_d   = S_ARMED;
        end else if (signal_wr) begin
          if (not_full) begin
            data_d[wr_idx] = data_in;
            attr_d[wr_idx] = attr_in;
            count_d        = count_q + CW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      S_ARMED, S_OUTPUT: begin
        if (signal_sel) begin
          sel_d     = data_in[SEL_WIDTH-1:0];
          sel_oor_d = sel_oor_in;
          state_d   = S_ARMED;
        end else if (signal_wr) begin
          // Stale slots 1..N-1 stay behind but are unreachable with count=1.
          data_d[0] = data_in;
          attr_d[0] = attr_in;
          count_d   = CW'(1);
          sel_d     = '0;
          sel_oor_d = 1'b0;
          ovf_d     = 1'b0;
          state_d   = S_COLLECT;
        end else if (signal_oe) begin
          state_d = S_OUTPUT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      sel_q     <= '0;
      sel_oor_q <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      for (int i = 0; i < int'(N); i++) begin
        data_q[i] <= '0;
        attr_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      sel_q     <= sel_d;
      sel_oor_q <= sel_oor_d;
      ovf_q     <= ovf_d;
      busy_q    <= (state_d != S_IDLE);
      data_q    <= data_d;
      attr_q    <= attr_d;
    end
  end

  assign valid = ((state_q == S_ARMED) || (state_q == S_OUTPUT)) &&
                 !sel_oor_q && ({1'b0, sel_q} < count_q);

  // Zero-latency bus drive; all-zero when not enabled so the bus can be OR-combined.
  always_comb begin
    data_out = '0;
    attr_out = '0;
    if (signal_oe) begin
      if (valid) begin
        data_out              = data_q[sel_q];
        attr_out              = attr_q[sel_q];
        attr_out[INVALID_BIT] = attr_q[sel_q][INVALID_BIT] | ovf_q;
      end else begin
        attr_out[INVALID_BIT] = 1'b1;
      end
    end
  end

  assign busy = busy_q;

endmodule
